// File: rtl/pulse_xfer_sched_pkg.sv
// Shared types for the pulse transfer scheduler: FSM state encoding,
// id-width helper and timeout counter width.
package pulse_xfer_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } xfer_state_e;

    localparam int N_REQ_DEF = 4;
    localparam int TMO_W     = 8;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W_DEF = id_width(N_REQ_DEF);

endpackage

// File: rtl/pulse_xfer_sched_rr_pick.sv
// Combinational round-robin picker: first set bit of pend searching
// upward from ptr+1 with wrap. Ports: pend, ptr in; win, valid out.
module rr_pick
    import pulse_xfer_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] pend,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  win,
    output logic             valid
);

    logic [ID_W:0] sum;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        win   = '0;
        valid = |pend;
        sum   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_REQ)) begin
                sum = sum - (ID_W+1)'(N_REQ);
            end
            if (pend[sum[ID_W-1:0]]) begin
                win = sum[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pulse_xfer_sched.sv
// Arbitrates N_REQ event requesters onto one four-phase pulse channel.
// Ports: clka, rst, req, ack, ovf_clr in; bit_a, xfer_id, busy, done, ovf, tmo_err out.
module pulse_xfer_sched
    import pulse_xfer_sched_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int TMO_CYC = 64,
    localparam int ID_W   = id_width(N_REQ)
) (
    input  logic             clka,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             ack,
    output logic             bit_a,
    output logic [ID_W-1:0]  xfer_id,
    output logic             busy,
    output logic             done,
    output logic [N_REQ-1:0] ovf,
    input  logic             ovf_clr,
    output logic             tmo_err
);

    xfer_state_e      state;
    xfer_state_e      state_nx;
    logic [N_REQ-1:0] pend;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] ovf_set;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  win;
    logic             win_vld;
    logic             issue;
    logic             done_nx;
    logic             tmo_hit;
    logic             tmo_fire;
    logic [TMO_W-1:0] tmo_cnt;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .pend  (pend),
        .ptr   (ptr),
        .win   (win),
        .valid (win_vld)
    );

    assign tmo_hit = (tmo_cnt == TMO_W'(TMO_CYC - 1));

    always_comb begin
        state_nx = state;
        tmo_fire = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (win_vld) state_nx = ST_SEND;
            end
            ST_SEND: begin
                state_nx = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (ack) begin
                    state_nx = ST_WAIT_LO;
                end else if (tmo_hit) begin
                    state_nx = ST_IDLE;
                    tmo_fire = 1'b1;
                end
            end
            ST_WAIT_LO: begin
                if (!ack) begin
                    state_nx = ST_IDLE;
                end else if (tmo_hit) begin
                    state_nx = ST_IDLE;
                    tmo_fire = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign issue   = (state == ST_IDLE) && win_vld;
    assign grant   = issue ? (N_REQ'(1) << win) : '0;
    // A req landing on its own grant cycle simply re-arms pending.
    assign ovf_set = req & pend & ~grant;
    assign done_nx = (state == ST_WAIT_LO) && !ack;

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            pend    <= '0;
            ovf     <= '0;
            tmo_err <= 1'b0;
            bit_a   <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            xfer_id <= '0;
            ptr     <= ID_W'(N_REQ - 1);
            tmo_cnt <= '0;
        end else begin
            state <= state_nx;
            pend  <= (pend & ~grant) | req;
            // New overflow beats a coincident clear.
            ovf   <= (ovf_clr ? '0 : ovf) | ovf_set;
            bit_a <= issue;
            done  <= done_nx;
            busy  <= (state_nx != ST_IDLE);
            if (issue) begin
                xfer_id <= win;
                ptr     <= win;
            end
            if (tmo_fire) begin
                tmo_err <= 1'b1;
            end
            if (state_nx != state) begin
                tmo_cnt <= '0;
            end else if (state == ST_WAIT_HI || state == ST_WAIT_LO) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pulse_xfer_sched.sv
// Directed bench for pulse_xfer_sched with an automatic ack responder.
// Outputs are sampled and inputs driven on the falling edge.
module tb_pulse_xfer_sched;

    logic       clka = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic       ack = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       bit_a;
    logic [1:0] xfer_id;
    logic       busy;
    logic       done;
    logic [3:0] ovf;
    logic       tmo_err;

    int n_tests = 0;
    int n_fail = 0;
    int n_bita = 0;
    int n_done = 0;
    int n_viol = 0;
    int id_log [0:63];
    int ack_rise = 1;
    int ack_fall = 1;
    bit ack_en = 1'b1;

    pulse_xfer_sched #(.N_REQ(4), .TMO_CYC(64)) dut (
        .clka    (clka),
        .rst     (rst),
        .req     (req),
        .ack     (ack),
        .bit_a   (bit_a),
        .xfer_id (xfer_id),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf),
        .ovf_clr (ovf_clr),
        .tmo_err (tmo_err)
    );

    always #5 clka = ~clka;

    always @(negedge clka) begin
        if (!rst) begin
            if (bit_a) begin
                if (n_bita < 64) id_log[n_bita] = int'(xfer_id);
                n_bita++;
                if (ack) n_viol++;
            end
            if (done) n_done++;
        end
    end

    initial begin
        forever begin
            @(negedge clka);
            if (bit_a && ack_en) begin
                repeat (ack_rise) @(negedge clka);
                ack = 1'b1;
                repeat (ack_fall) @(negedge clka);
                ack = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_req(input logic [3:0] v);
        req = v;
        @(negedge clka);
        req = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        ovf_clr = 1'b0;
        repeat (2) @(negedge clka);
        rst = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target,
                             input int budget);
        for (int i = 0; i < budget; i++) begin
            if (n_done >= target) break;
            @(negedge clka);
        end
        chk(tag, n_done, target);
    endtask

    task automatic wait_bita(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (bit_a) break;
            @(negedge clka);
        end
        chk(tag, bit_a, 1);
    endtask

    int b0;
    int d0;

    initial begin
        @(negedge clka);
        do_reset();
        chk("rst_bit_a", bit_a, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_tmo", tmo_err, 0);
        chk("rst_id", xfer_id, 0);

        // Single transfer, slow ack, latency check.
        ack_rise = 3;
        ack_fall = 3;
        b0 = n_bita;
        d0 = n_done;
        pulse_req(4'b0001);
        chk("lat_pend_bita", bit_a, 0);
        chk("lat_pend_busy", busy, 0);
        @(negedge clka);
        chk("lat_bita", bit_a, 1);
        chk("lat_id", xfer_id, 0);
        chk("lat_busy", busy, 1);
        wait_done("s1_done", d0 + 1, 40);
        @(negedge clka);
        chk("s1_busy_after", busy, 0);
        chk("s1_bita_cnt", n_bita - b0, 1);
        chk("s1_done_cnt", n_done - d0, 1);
        chk("s1_id_hold", xfer_id, 0);

        // All four at once from reset: order 0,1,2,3.
        do_reset();
        ack_rise = 1;
        ack_fall = 1;
        b0 = n_bita;
        d0 = n_done;
        pulse_req(4'b1111);
        wait_done("s2_done", d0 + 4, 200);
        chk("s2_bita_cnt", n_bita - b0, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("s2_order%0d", i), id_log[b0 + i], i);
        end
        chk("s2_ovf", ovf, 0);

        // Overflow on id 2 while the channel is busy with id 0.
        ack_rise = 5;
        ack_fall = 2;
        b0 = n_bita;
        d0 = n_done;
        req = 4'b0001;
        @(negedge clka);
        req = 4'b0100;
        @(negedge clka);
        req = 4'b0100;
        @(negedge clka);
        req = 4'b0000;
        chk("s3_ovf_set", ovf, 4'b0100);
        wait_done("s3_done", d0 + 2, 100);
        chk("s3_bita_cnt", n_bita - b0, 2);
        chk("s3_id0", id_log[b0], 0);
        chk("s3_id1", id_log[b0 + 1], 2);
        chk("s3_ovf_keep", ovf, 4'b0100);
        ovf_clr = 1'b1;
        @(negedge clka);
        ovf_clr = 1'b0;
        chk("s3_ovf_clr", ovf, 0);

        // Clear coincident with a fresh overflow: overflow wins.
        d0 = n_done;
        req = 4'b0001;
        @(negedge clka);
        req = 4'b0010;
        @(negedge clka);
        req = 4'b0010;
        ovf_clr = 1'b1;
        @(negedge clka);
        req = 4'b0000;
        ovf_clr = 1'b0;
        chk("s3_clr_vs_ovf", ovf, 4'b0010);
        wait_done("s3b_done", d0 + 2, 100);
        ovf_clr = 1'b1;
        @(negedge clka);
        ovf_clr = 1'b0;
        chk("s3b_ovf_clr", ovf, 0);

        // Ack never arrives: timeout after exactly 64 cycles.
        ack_en = 1'b0;
        ack_rise = 1;
        ack_fall = 1;
        d0 = n_done;
        pulse_req(4'b0010);
        wait_bita("s4_bita", 10);
        chk("s4_id", xfer_id, 1);
        repeat (64) @(negedge clka);
        chk("s4_tmo_early", tmo_err, 0);
        chk("s4_busy_early", busy, 1);
        @(negedge clka);
        chk("s4_tmo", tmo_err, 1);
        chk("s4_busy", busy, 0);
        chk("s4_no_done", n_done - d0, 0);
        ack_en = 1'b1;
        b0 = n_bita;
        pulse_req(4'b1000);
        wait_done("s4_next_done", d0 + 1, 40);
        chk("s4_next_id", id_log[b0], 3);
        chk("s4_tmo_sticky", tmo_err, 1);

        // Reset while waiting for ack abandons the transfer.
        ack_en = 1'b0;
        pulse_req(4'b0010);
        wait_bita("s5_bita", 10);
        @(negedge clka);
        chk("s5_busy_wait", busy, 1);
        rst = 1'b1;
        @(negedge clka);
        chk("s5_rst_bita", bit_a, 0);
        chk("s5_rst_busy", busy, 0);
        chk("s5_rst_done", done, 0);
        chk("s5_rst_id", xfer_id, 0);
        chk("s5_rst_ovf", ovf, 0);
        chk("s5_rst_tmo", tmo_err, 0);
        rst = 1'b0;
        ack_en = 1'b1;
        @(negedge clka);
        chk("s5_no_resume", busy, 0);
        b0 = n_bita;
        d0 = n_done;
        pulse_req(4'b0010);
        wait_done("s5_done", d0 + 1, 40);
        chk("s5_id", id_log[b0], 1);

        // Req on id 3 in its own grant cycle re-arms it.
        b0 = n_bita;
        d0 = n_done;
        req = 4'b1000;
        @(negedge clka);
        req = 4'b1000;
        @(negedge clka);
        req = 4'b0000;
        wait_done("s6_done", d0 + 2, 100);
        chk("s6_bita_cnt", n_bita - b0, 2);
        chk("s6_id0", id_log[b0], 3);
        chk("s6_id1", id_log[b0 + 1], 3);
        chk("s6_ovf", ovf, 0);

        chk("four_phase", n_viol, 0);

        repeat (3) @(negedge clka);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
